// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed, checksummed word stream from the
// host, writes it into the instruction memory, and keeps the CPU in reset until a load
// has been length-checked and checksum-verified.
module imem_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 10,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrZeroLen  = 2'b01;
  localparam logic [1:0] ErrChecksum = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLen, StData, StCheck, StDone, StError} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CntW-1:0]   idle_q, idle_d;
  logic [1:0]        err_code_d;
  logic              accept;
  logic              idle_expired;

  logic              in_ready_d, imem_we_d, cpu_hold_d, done_d, error_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_d;

  // in_ready is registered from the next state, so it is high exactly in LEN/DATA/CHECK
  assign accept       = in_valid & in_ready;
  assign idle_expired = (idle_q == CntW'(TIMEOUT_CYCLES - 1));

  // State, length, index, running checksum and idle counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state logic: stream parsing, checksum accumulation and idle timeout
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    idle_d     = idle_q;
    err_code_d = err_code;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLen;
          idle_d  = '0;
        end
      end
      StLen: begin
        if (accept) begin
          if (in_data == '0) begin
            state_d    = StError;
            err_code_d = ErrZeroLen;
          end else begin
            state_d = StData;
            len_d   = in_data;
            idx_d   = '0;
            sum_d   = '0;
          end
        end
      end
      StData: begin
        if (accept) begin
          sum_d = sum_q + in_data;
          idx_d = idx_q + DATA_W'(1);
          if (idx_d == len_q) state_d = StCheck;
        end
      end
      StCheck: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = StDone;
          end else begin
            state_d    = StError;
            err_code_d = ErrChecksum;
          end
        end
      end
      StDone, StError: begin
        if (start) begin
          state_d    = StLen;
          err_code_d = ErrNone;
          idle_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    // An accept in the expiry cycle wins over the timeout
    if (state_q inside {StLen, StData, StCheck}) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_expired) begin
        state_d    = StError;
        err_code_d = ErrTimeout;
      end else begin
        idle_d = idle_q + CntW'(1);
      end
    end
  end

  // Output next values; memory write issued the cycle after each DATA accept
  always_comb begin
    in_ready_d   = state_d inside {StLen, StData, StCheck};
    done_d       = (state_d == StDone);
    error_d      = (state_d == StError);
    cpu_hold_d   = (state_d != StDone);
    imem_we_d    = (state_q == StData) && accept;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    if (imem_we_d) begin
      imem_addr_d  = ADDR_W'(BASE_ADDR + 32'(idx_q));
      imem_wdata_d = in_data;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ErrNone;
    end else begin
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
      error      <= error_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 1022) share one host stream;
// expected writes and final status come from a stream-level model of the load rules.
module tb_imem_loader;

  localparam int unsigned TO    = 16;
  localparam int unsigned BASE1 = 1022;

  typedef logic [9:0] word_t;
  typedef struct {
    int    cyc;
    word_t addr;
    word_t data;
  } wr_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  start = 1'b0;
  logic  in_valid = 1'b0;
  word_t in_data = '0;

  logic       in_ready0, imem_we0, cpu_hold0, done0, error0;
  word_t      imem_addr0, imem_wdata0;
  logic [1:0] err_code0;
  logic       in_ready1, imem_we1, cpu_hold1, done1, error1;
  word_t      imem_addr1, imem_wdata1;
  logic [1:0] err_code1;

  int  checks = 0;
  int  passed = 0;
  int  cyc = 0;
  wr_t wq0[$];
  wr_t wq1[$];

  imem_loader #(.ADDR_W(10), .DATA_W(10), .BASE_ADDR(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .cpu_hold(cpu_hold0), .done(done0), .error(error0),
    .err_code(err_code0)
  );

  imem_loader #(.ADDR_W(10), .DATA_W(10), .BASE_ADDR(BASE1), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .cpu_hold(cpu_hold1), .done(done1), .error(error1),
    .err_code(err_code1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write seen by each instance
  always @(negedge clk) begin
    if (imem_we0) wq0.push_back('{cyc, imem_addr0, imem_wdata0});
    if (imem_we1) wq1.push_back('{cyc, imem_addr1, imem_wdata1});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Present one word and hold it until accepted; called and returns at a falling edge
  task automatic drive_word(input word_t w);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 40) begin
      acc = in_ready0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!acc) $display("FAIL handshake: word %0h accepted=%0b want 1", w, acc);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready0, imem_we0, imem_addr0, imem_wdata0, cpu_hold0, done0, error0, err_code0}
        !== {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 2'b00})
      $display("FAIL reset0: got rdy=%0b we=%0b a=%0h d=%0h hold=%0b done=%0b err=%0b code=%0d",
               in_ready0, imem_we0, imem_addr0, imem_wdata0, cpu_hold0, done0, error0,
               err_code0);
    else passed++;
    checks++;
    if ({in_ready1, imem_we1, imem_addr1, cpu_hold1, done1, error1, err_code1}
        !== {1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 2'b00})
      $display("FAIL reset1: got rdy=%0b we=%0b a=%0h hold=%0b done=%0b err=%0b code=%0d",
               in_ready1, imem_we1, imem_addr1, cpu_hold1, done1, error1, err_code1);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Full load from IDLE/DONE/ERROR with model-derived expectations
  task automatic test_load(input string name, input word_t words[$], input int gap_max,
                           input bit consec, input bit start_mid);
    int         n, exp_err, g;
    word_t      sum;
    logic [5:0] exp_st;
    wr_t        q[$];
    int unsigned base;
    n   = int'(words[0]);
    sum = '0;
    for (int i = 1; i <= n; i++) sum = sum + words[i];
    exp_err = (n == 0) ? 1 : ((words[n+1] == sum) ? 0 : 2);
    wq0.delete();
    wq1.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      if (start_mid && i == 2 && n >= 2) begin
        start = 1'b1;
        drive_word(words[i]);
        start = 1'b0;
      end else begin
        drive_word(words[i]);
      end
    end
    in_valid = 1'b0;
    exp_st = {(exp_err == 0), (exp_err != 0), 2'(exp_err), (exp_err != 0), 1'b0};
    checks++;
    if ({done0, error0, err_code0, cpu_hold0, in_ready0} !== exp_st)
      $display("FAIL %s status0: got done/err/code/hold/rdy=%b want %b", name,
               {done0, error0, err_code0, cpu_hold0, in_ready0}, exp_st);
    else passed++;
    checks++;
    if ({done1, error1, err_code1, cpu_hold1, in_ready1} !== exp_st)
      $display("FAIL %s status1: got done/err/code/hold/rdy=%b want %b", name,
               {done1, error1, err_code1, cpu_hold1, in_ready1}, exp_st);
    else passed++;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        q = wq0;
        base = 0;
      end else begin
        q = wq1;
        base = BASE1;
      end
      checks++;
      if (q.size() != n)
        $display("FAIL %s wr_count%0d: got %0d want %0d", name, d, q.size(), n);
      else passed++;
      for (int i = 0; i < n && i < q.size(); i++) begin
        checks++;
        if (q[i].addr !== word_t'((base + i) % 1024) || q[i].data !== words[i+1])
          $display("FAIL %s wr%0d[%0d]: got %0h@%0h want %0h@%0h", name, d, i, q[i].data,
                   q[i].addr, words[i+1], word_t'((base + i) % 1024));
        else passed++;
      end
    end
    if (consec) begin
      for (int i = 1; i < wq0.size(); i++) begin
        checks++;
        if (wq0[i].cyc !== wq0[i-1].cyc + 1)
          $display("FAIL %s consec[%0d]: got cycle %0d want %0d", name, i, wq0[i].cyc,
                   wq0[i-1].cyc + 1);
        else passed++;
      end
    end
  endtask

  task automatic test_basic();
    test_load("basic", '{10'd3, 10'h081, 10'h1FF, 10'h3C0, 10'h240}, 0, 1'b1, 1'b0);
  endtask

  task automatic test_checksum_err();
    test_load("bad_ck", '{10'd3, 10'h081, 10'h1FF, 10'h3C0, 10'h241}, 0, 1'b0, 1'b0);
    test_load("recover", '{10'd3, 10'h081, 10'h1FF, 10'h3C0, 10'h240}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    test_load("zero_len", '{10'd0}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    test_load("wrap", '{10'd4, 10'h011, 10'h022, 10'h033, 10'h044, 10'h0AA}, 0, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    test_load("start_mid", '{10'd4, 10'h3FF, 10'h001, 10'h155, 10'h2AA, 10'h3FF}, 0, 1'b1,
              1'b1);
  endtask

  task automatic test_timeout();
    wq0.delete();
    wq1.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_word(10'd5);
    drive_word(10'h123);
    drive_word(10'h045);
    in_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (error0 !== 1'b0 || in_ready0 !== 1'b1)
      $display("FAIL timeout_early: got err=%0b rdy=%0b want 0 1", error0, in_ready0);
    else passed++;
    @(negedge clk);
    checks++;
    if ({error0, err_code0, cpu_hold0, done0, in_ready0} !== 6'b111100)
      $display("FAIL timeout0: got err/code/hold/done/rdy=%b want 111100",
               {error0, err_code0, cpu_hold0, done0, in_ready0});
    else passed++;
    checks++;
    if ({error1, err_code1} !== 3'b111)
      $display("FAIL timeout1: got err/code=%b want 111", {error1, err_code1});
    else passed++;
    checks++;
    if (wq0.size() != 2) $display("FAIL timeout_writes: got %0d want 2", wq0.size());
    else passed++;
  endtask

  task automatic test_timeout_edge();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_word(10'd2);
    drive_word(10'h200);
    in_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    drive_word(10'h0F0);
    in_valid = 1'b0;
    checks++;
    if ({error0, err_code0, in_ready0} !== 4'b0001)
      $display("FAIL expiry_accept: got err/code/rdy=%b want 0001",
               {error0, err_code0, in_ready0});
    else passed++;
    drive_word(10'h2F0);
    in_valid = 1'b0;
    checks++;
    if ({done0, error0, cpu_hold0} !== 3'b100)
      $display("FAIL expiry_done: got done/err/hold=%b want 100", {done0, error0, cpu_hold0});
    else passed++;
  endtask

  task automatic test_random();
    word_t words[$];
    word_t sum;
    int    n;
    for (int k = 0; k < 8; k++) begin
      words.delete();
      n = $urandom_range(12, 1);
      words.push_back(word_t'(n));
      sum = '0;
      for (int i = 0; i < n; i++) begin
        words.push_back(word_t'($urandom));
        sum = sum + words[i+1];
      end
      if ($urandom_range(3, 0) == 0) sum = sum + word_t'($urandom_range(1023, 1));
      words.push_back(sum);
      test_load($sformatf("rand%0d", k), words, 3, 1'b0, 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_word(10'd20);
    drive_word(10'h111);
    drive_word(10'h222);
    // in_valid stays high: the burst continues into the next edge
    checks++;
    if (imem_we0 !== 1'b1) $display("FAIL burst_we: got %0b want 1", imem_we0);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    wq0.delete();
    wq1.delete();
    checks++;
    if ({in_ready0, imem_we0, imem_addr0, imem_wdata0, cpu_hold0, done0, error0, err_code0}
        !== {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 2'b00})
      $display("FAIL async_reset0: got rdy=%0b we=%0b a=%0h d=%0h hold=%0b want 0 0 0 0 1",
               in_ready0, imem_we0, imem_addr0, imem_wdata0, cpu_hold0);
    else passed++;
    checks++;
    if ({in_ready1, imem_we1, imem_addr1, cpu_hold1} !== {1'b0, 1'b0, 10'd0, 1'b1})
      $display("FAIL async_reset1: got rdy=%0b we=%0b a=%0h hold=%0b want 0 0 0 1",
               in_ready1, imem_we1, imem_addr1, cpu_hold1);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = word_t'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (wq0.size() != 0 || wq1.size() != 0 || in_ready0 !== 1'b0)
      $display("FAIL idle_valid: got writes=%0d/%0d rdy=%0b want 0/0 0", wq0.size(),
               wq1.size(), in_ready0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum_err();
    test_zero_len();
    test_wrap();
    test_start_ignored();
    test_timeout();
    test_timeout_edge();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
